counting_bloom_update: RTL and testbench

COUNTING_BLOOM_UPDATE -- requirements
Module: counting_bloom_update

---
 rtl/cbf_pkg.sv | 21 ++
 rtl/cbf_ctr_step.sv | 33 +++
 rtl/counting_bloom_update.sv | 146 ++++++++++++++
 tb/tb_counting_bloom_update.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cbf_pkg.sv
// Shared types for the counting Bloom filter update block:
// op codes, FSM state encoding and the default counter width.
package cbf_pkg;

  localparam int CTR_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_QUERY  = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_STEP0 = 2'b01,
    S_STEP1 = 2'b10,
    S_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/cbf_ctr_step.sv
// One saturating counter update step.
// Ports: i_value/i_op in; o_next, o_is_zero, o_is_full out.
module cbf_ctr_step
  import cbf_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic [CTR_W-1:0] i_value,
  input  op_e              i_op,
  output logic [CTR_W-1:0] o_next,
  output logic             o_is_zero,
  output logic             o_is_full
);

  logic w_zero;
  logic w_full;

  // OR-tree zero detect, AND-tree all-ones detect
  assign w_zero    = ~(|i_value);
  assign w_full    = &i_value;
  assign o_is_zero = w_zero;
  assign o_is_full = w_full;

  always_comb begin
    o_next = i_value;
    unique case (i_op)
      OP_INSERT: if (!w_full) o_next = i_value + 1'b1;
      OP_DELETE: if (!w_zero) o_next = i_value - 1'b1;
      default:   o_next = i_value;
    endcase
  end

endmodule

// File: rtl/counting_bloom_update.sv
// Counting Bloom filter bank: query/insert/delete/clear on two
// hash indices, one index per step. Optional macro CBF_SAT_STATS_EN
// enables the saturation event counter on sat_count.
// Ports: clk, rst (sync, high); req_valid/req_ready/req_op/
// req_idx0/req_idx1 in; resp_valid/resp_hit/resp_sat/sat_count out.
module counting_bloom_update
  import cbf_pkg::*;
#(
  parameter int NUM_CTR = 16,
  parameter int CTR_W   = CTR_W_DEF,
  localparam int IDX_W  = $clog2(NUM_CTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_idx0,
  input  logic [IDX_W-1:0] req_idx1,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic             resp_sat,
  output logic [15:0]      sat_count
);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [IDX_W-1:0] r_idx0;
  logic [IDX_W-1:0] r_idx1;
  logic [CTR_W-1:0] r_ctr [NUM_CTR];
  logic             r_nz0;
  logic             r_sat;
  logic             r_hit;
  logic             r_resp_sat;

  logic [IDX_W-1:0] w_sel;
  logic [CTR_W-1:0] w_cur;
  logic [CTR_W-1:0] w_nxt;
  logic             w_zero;
  logic             w_full;
  logic             w_step_sat;
  logic             w_resp_sat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_next = S_STEP0;
      S_STEP0: w_next = S_STEP1;
      S_STEP1: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
  end

  // One shared step unit; STEP1 reads the array after the
  // STEP0 write, so idx0==idx1 applies the op twice.
  assign w_sel = (r_state == S_STEP1) ? r_idx1 : r_idx0;
  assign w_cur = r_ctr[w_sel];

  cbf_ctr_step #(.CTR_W(CTR_W)) u_step (
    .i_value   (w_cur),
    .i_op      (r_op),
    .o_next    (w_nxt),
    .o_is_zero (w_zero),
    .o_is_full (w_full)
  );

  assign w_step_sat = ((r_op == OP_INSERT) && w_full) ||
                      ((r_op == OP_DELETE) && w_zero);
  assign w_resp_sat = r_sat | w_step_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTR; i++) r_ctr[i] <= '0;
      r_op       <= OP_QUERY;
      r_idx0     <= '0;
      r_idx1     <= '0;
      r_nz0      <= 1'b0;
      r_sat      <= 1'b0;
      r_hit      <= 1'b0;
      r_resp_sat <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op   <= op_e'(req_op);
            r_idx0 <= req_idx0;
            r_idx1 <= req_idx1;
            r_sat  <= 1'b0;
          end
        end
        S_STEP0: begin
          if (r_op == OP_CLEAR) begin
            for (int i = 0; i < NUM_CTR; i++) r_ctr[i] <= '0;
          end else begin
            r_ctr[w_sel] <= w_nxt;
          end
          r_nz0 <= ~w_zero;
          r_sat <= w_step_sat;
        end
        S_STEP1: begin
          if (r_op != OP_CLEAR) r_ctr[w_sel] <= w_nxt;
          r_hit      <= (r_op == OP_QUERY) && r_nz0 && !w_zero;
          r_resp_sat <= w_resp_sat;
        end
        default: ;
      endcase
    end
  end

  assign resp_hit = r_hit;
  assign resp_sat = r_resp_sat;

`ifdef CBF_SAT_STATS_EN
  logic [15:0] r_sat_cnt;

  // Counted on the STEP1->RESP edge, so it is current during RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if ((r_state == S_STEP1) && w_resp_sat &&
                 (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_count = r_sat_cnt;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_counting_bloom_update.sv
// Directed bench for counting_bloom_update: vector table plus
// saturation, held-valid and mid-flight reset sequences.
module tb_counting_bloom_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_idx0;
  logic [3:0]  req_idx1;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_sat;
  logic [15:0] sat_count;

  int n_cmp = 0;
  int n_bad = 0;
  int m_sat = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] i0;
    logic [3:0] i1;
    bit         hit;
    bit         sat;
  } vec_t;

  vec_t vecs [11];

  counting_bloom_update #(.NUM_CTR(16), .CTR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_idx0   (req_idx0),
    .req_idx1   (req_idx1),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_sat   (resp_sat),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Edge 1 is the accept edge; RESP is expected after edge 3.
  task automatic run(input logic [1:0] op, input logic [3:0] i0,
                     input logic [3:0] i1, input bit hold,
                     output int lat, output int pulses,
                     output bit hit, output bit sat,
                     output int busy_rdy);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_idx0  = i0;
    req_idx1  = i1;
    lat = -1; pulses = 0; hit = 0; sat = 0; busy_rdy = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (!hold || k == 4) req_valid = 1'b0;
      if (k <= 3 && req_ready) busy_rdy++;
      if (resp_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          hit = resp_hit;
          sat = resp_sat;
        end
      end
    end
  endtask

  task automatic apply(input string nm, input logic [1:0] op,
                       input logic [3:0] i0, input logic [3:0] i1,
                       input bit ehit, input bit esat);
    int lat, pulses, brdy;
    bit hit, sat;
    run(op, i0, i1, 1'b0, lat, pulses, hit, sat, brdy);
    chk({nm, ".lat"}, lat, 3);
    chk({nm, ".pulses"}, pulses, 1);
    chk({nm, ".hit"}, hit, ehit);
    chk({nm, ".sat"}, sat, esat);
    chk({nm, ".busy_ready"}, brdy, 0);
    if (esat) m_sat++;
  endtask

  function automatic int exp_cnt();
`ifdef CBF_SAT_STATS_EN
    return m_sat;
`else
    return 0;
`endif
  endfunction

  initial begin
    int lat, pulses, brdy, bad;
    bit hit, sat;

    // op: 0 query, 1 insert, 2 delete, 3 clear
    vecs[0]  = '{2'd1, 4'd3, 4'd5, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 4'd3, 4'd5, 1'b1, 1'b0};
    vecs[2]  = '{2'd0, 4'd3, 4'd6, 1'b0, 1'b0};
    vecs[3]  = '{2'd2, 4'd2, 4'd4, 1'b0, 1'b1};
    vecs[4]  = '{2'd0, 4'd2, 4'd4, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 4'd3, 4'd3, 1'b0, 1'b0};
    vecs[6]  = '{2'd2, 4'd5, 4'd5, 1'b0, 1'b1};
    vecs[7]  = '{2'd0, 4'd3, 4'd5, 1'b0, 1'b0};
    vecs[8]  = '{2'd0, 4'd3, 4'd3, 1'b1, 1'b0};
    vecs[9]  = '{2'd3, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{2'd0, 4'd3, 4'd3, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0;
    req_idx0 = 4'd0; req_idx1 = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.ready", req_ready, 1);
    chk("rst.valid", resp_valid, 0);
    chk("rst.hit", resp_hit, 0);
    chk("rst.sat", resp_sat, 0);
    chk("rst.sat_count", sat_count, 0);

    for (int v = 0; v < 11; v++)
      apply($sformatf("vec%0d", v), vecs[v].op, vecs[v].i0,
            vecs[v].i1, vecs[v].hit, vecs[v].sat);
    chk("sat_count.table", sat_count, exp_cnt());

    // Drive counter 7 to 254 with 127 double inserts
    bad = 0;
    for (int n = 0; n < 127; n++) begin
      run(2'd1, 4'd7, 4'd7, 1'b0, lat, pulses, hit, sat, brdy);
      if (lat != 3 || pulses != 1 || sat) bad++;
    end
    chk("fill7.bad", bad, 0);
    apply("ins7.254", 2'd1, 4'd7, 4'd7, 1'b0, 1'b1);
    chk("sat_count.ins7", sat_count, exp_cnt());
    apply("ins7.255", 2'd1, 4'd7, 4'd7, 1'b0, 1'b1);
    apply("del7.253", 2'd2, 4'd7, 4'd7, 1'b0, 1'b0);
    apply("qry7", 2'd0, 4'd7, 4'd7, 1'b1, 1'b0);
    chk("sat_count.sat", sat_count, exp_cnt());

    // Valid held high through STEP0..RESP: one accept only
    run(2'd1, 4'd1, 4'd1, 1'b1, lat, pulses, hit, sat, brdy);
    chk("hold.lat", lat, 3);
    chk("hold.pulses", pulses, 1);
    chk("hold.busy_ready", brdy, 0);
    chk("hold.sat", sat, 0);
    apply("hold.q", 2'd0, 4'd1, 4'd1, 1'b1, 1'b0);

    // Reset while an insert is in STEP1
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1;
    req_idx0 = 4'd8; req_idx1 = 4'd9;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_sat = 0;
    chk("midrst.ready", req_ready, 1);
    chk("midrst.valid", resp_valid, 0);
    chk("midrst.sat_count", sat_count, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    chk("midrst.pulses", pulses, 0);
    apply("midrst.q89", 2'd0, 4'd8, 4'd9, 1'b0, 1'b0);
    apply("midrst.q77", 2'd0, 4'd7, 4'd7, 1'b0, 1'b0);
    apply("midrst.q11", 2'd0, 4'd1, 4'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
